// File: rtl/m3_ramp_step_sequencer.sv
// m3_ramp_step_sequencer
// Commutation step sequencer for a three-phase motor drive. Produces the step
// index (0..STEPS-1) at a programmable per-step period, ramps period and power
// on INC/DEC pulses with clamping, supports reverse rotation, a controlled
// deceleration on stop and an immediate force-stop.
//
// Ports:
//   clkI, nRstI          clock, asynchronous active-low reset
//   m3startI             level: 1 = run, 0 = decelerate and stop
//   m3forceStopI         level: immediate halt, power forced to 0
//   m3invRotateI         direction request, latched on IDLE -> RUN
//   m3freqINCi/DECi      pulses: shorten / lengthen the step period
//   m3powerINCi/DECi     pulses: raise / lower the power level
//   stepO                current step index
//   stepStrobeO          one-cycle pulse on the first cycle of each step
//   roundStrobeO         one-cycle pulse when the step index wraps
//   periodO              active step period in clkI cycles
//   powerO               active power (0 outside RUN/DECEL)
//   runningO             1 in RUN or DECEL
//   dirO                 latched direction, 1 = reverse
// Optional (macro M3_RAMP_STATS_EN):
//   roundCntO            saturating count of roundStrobeO pulses
//   clampO               one-cycle pulse when a period/power update saturated
module m3_ramp_step_sequencer #(
    parameter int PERIOD_W   = 22,
    parameter int PERIOD_MAX = 4000000,
    parameter int PERIOD_MIN = 40,
    parameter int STEPS      = 12,
    parameter int STEP_W     = 4,
    parameter int POWER_W    = 10,
    parameter int POWER_MAX  = 1000,
    parameter int POWER_INIT = 100,
    parameter int POWER_STEP = 10,
    parameter int RAMP_SHIFT = 5
) (
    input  logic                clkI,
    input  logic                nRstI,
    input  logic                m3startI,
    input  logic                m3forceStopI,
    input  logic                m3invRotateI,
    input  logic                m3freqINCi,
    input  logic                m3freqDECi,
    input  logic                m3powerINCi,
    input  logic                m3powerDECi,
    output logic [STEP_W-1:0]   stepO,
    output logic                stepStrobeO,
    output logic                roundStrobeO,
    output logic [PERIOD_W-1:0] periodO,
    output logic [POWER_W-1:0]  powerO,
    output logic                runningO,
    output logic                dirO
`ifdef M3_RAMP_STATS_EN
    ,
    output logic [15:0]         roundCntO,
    output logic                clampO
`endif
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DECEL = 2'd2, HALT = 2'd3} state_t;

    localparam logic [1:0] REQ_NONE = 2'b00;
    localparam logic [1:0] REQ_INC  = 2'b01;
    localparam logic [1:0] REQ_DEC  = 2'b10;

    localparam logic [PERIOD_W-1:0] P_MAX     = PERIOD_W'(PERIOD_MAX);
    localparam logic [PERIOD_W-1:0] P_MIN     = PERIOD_W'(PERIOD_MIN);
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEPS - 1);
    localparam logic [POWER_W:0]    PW_MAX    = (POWER_W+1)'(POWER_MAX);
    localparam logic [POWER_W:0]    PW_STEP   = (POWER_W+1)'(POWER_STEP);
    localparam logic [POWER_W-1:0]  PW_INIT   = POWER_W'(POWER_INIT);

    // Period ramp: returns {saturated, newPeriod}; faster=1 shortens the period.
    function automatic logic [PERIOD_W:0] rampPeriod(input logic [PERIOD_W-1:0] p,
                                                     input logic faster);
        logic [PERIOD_W:0] delta;
        logic [PERIOD_W:0] sum;
        delta = {1'b0, p >> RAMP_SHIFT};
        delta = (delta == '0) ? (PERIOD_W+1)'(1) : delta;
        sum   = {1'b0, p} + delta;
        if (faster) begin
            // Compare before subtracting so the counter can never wrap.
            if ({1'b0, p} < ({1'b0, P_MIN} + delta)) begin
                rampPeriod = {1'b1, P_MIN};
            end else begin
                rampPeriod = {1'b0, p - delta[PERIOD_W-1:0]};
            end
        end else begin
            if (sum > {1'b0, P_MAX}) begin
                rampPeriod = {1'b1, P_MAX};
            end else begin
                rampPeriod = {1'b0, sum[PERIOD_W-1:0]};
            end
        end
    endfunction

    // Power ramp on POWER_W+1 bits: returns {saturated, newPower}.
    function automatic logic [POWER_W:0] rampPower(input logic [POWER_W-1:0] p,
                                                   input logic up);
        logic [POWER_W:0] wide;
        if (up) begin
            wide = {1'b0, p} + PW_STEP;
            if (wide > PW_MAX) begin
                rampPower = {1'b1, PW_MAX[POWER_W-1:0]};
            end else begin
                rampPower = {1'b0, wide[POWER_W-1:0]};
            end
        end else begin
            wide = {1'b0, p} - PW_STEP;
            if ({1'b0, p} < PW_STEP) begin
                rampPower = {1'b1, {POWER_W{1'b0}}};
            end else begin
                rampPower = {1'b0, wide[POWER_W-1:0]};
            end
        end
    endfunction

    state_t              stateR;
    logic [PERIOD_W-1:0] remainR;
    logic [1:0]          freqPendR;
    logic [1:0]          powerPendR;

    logic                runActiveS;
    logic                boundaryS;
    logic                wrapS;
    logic                roundS;
    logic [STEP_W-1:0]   nextStepS;
    logic [PERIOD_W:0]   freqResS;
    logic                freqApplyS;
    logic [PERIOD_W-1:0] nextPeriodS;
    logic [POWER_W:0]    powerResS;
    logic                powerApplyS;
    logic [POWER_W-1:0]  nextPowerS;
    logic [1:0]          freqPendNextS;
    logic [1:0]          powerPendNextS;

    // Step timing, wrap detection, pending-request handling and ramp results.
    always_comb begin
        runActiveS  = ((stateR == RUN) || (stateR == DECEL)) && !m3forceStopI;
        boundaryS   = runActiveS && (remainR == PERIOD_W'(1));
        wrapS       = dirO ? (stepO == '0) : (stepO == STEP_LAST);
        roundS      = boundaryS && wrapS;
        nextStepS   = stepO;
        if (dirO) begin
            nextStepS = wrapS ? STEP_LAST : (stepO - STEP_W'(1));
        end else begin
            nextStepS = wrapS ? '0 : (stepO + STEP_W'(1));
        end

        // DECEL always stretches the period; RUN follows the pending request.
        freqResS = {1'b0, periodO};
        if (stateR == DECEL) begin
            freqResS = rampPeriod(periodO, 1'b0);
        end else if (freqPendR == REQ_INC) begin
            freqResS = rampPeriod(periodO, 1'b1);
        end else if (freqPendR == REQ_DEC) begin
            freqResS = rampPeriod(periodO, 1'b0);
        end else begin
            freqResS = {1'b0, periodO};
        end
        // A DECEL round ending at the slowest period stops instead of ramping.
        if (stateR == DECEL) begin
            freqApplyS = roundS && (periodO != P_MAX);
        end else begin
            freqApplyS = roundS && (freqPendR != REQ_NONE);
        end
        nextPeriodS = freqApplyS ? freqResS[PERIOD_W-1:0] : periodO;

        powerResS   = rampPower(powerO, powerPendR == REQ_INC);
        powerApplyS = boundaryS && (powerPendR != REQ_NONE);
        nextPowerS  = powerApplyS ? powerResS[POWER_W-1:0] : powerO;

        // Latest single pulse wins; simultaneous INC+DEC leaves the request as is.
        if (m3freqINCi && !m3freqDECi) begin
            freqPendNextS = REQ_INC;
        end else if (m3freqDECi && !m3freqINCi) begin
            freqPendNextS = REQ_DEC;
        end else begin
            freqPendNextS = freqApplyS ? REQ_NONE : freqPendR;
        end
        if (m3powerINCi && !m3powerDECi) begin
            powerPendNextS = REQ_INC;
        end else if (m3powerDECi && !m3powerINCi) begin
            powerPendNextS = REQ_DEC;
        end else begin
            powerPendNextS = powerApplyS ? REQ_NONE : powerPendR;
        end
    end

    // Sequencer FSM with all registered outputs.
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            stateR       <= IDLE;
            remainR      <= P_MAX;
            freqPendR    <= REQ_NONE;
            powerPendR   <= REQ_NONE;
            stepO        <= '0;
            stepStrobeO  <= 1'b0;
            roundStrobeO <= 1'b0;
            periodO      <= P_MAX;
            powerO       <= '0;
            runningO     <= 1'b0;
            dirO         <= 1'b0;
        end else begin
            stepStrobeO  <= 1'b0;
            roundStrobeO <= 1'b0;
            if (m3forceStopI) begin
                stateR     <= HALT;
                powerO     <= '0;
                runningO   <= 1'b0;
                freqPendR  <= REQ_NONE;
                powerPendR <= REQ_NONE;
            end else begin
                case (stateR)
                    IDLE: begin
                        freqPendR  <= REQ_NONE;
                        powerPendR <= REQ_NONE;
                        if (m3startI) begin
                            stateR   <= RUN;
                            dirO     <= m3invRotateI;
                            stepO    <= '0;
                            periodO  <= P_MAX;
                            remainR  <= P_MAX;
                            powerO   <= PW_INIT;
                            runningO <= 1'b1;
                        end else begin
                            stateR   <= IDLE;
                            powerO   <= '0;
                            runningO <= 1'b0;
                        end
                    end
                    HALT: begin
                        freqPendR  <= REQ_NONE;
                        powerPendR <= REQ_NONE;
                        powerO     <= '0;
                        runningO   <= 1'b0;
                        stateR     <= m3startI ? HALT : IDLE;
                    end
                    RUN, DECEL: begin
                        if (boundaryS) begin
                            remainR      <= nextPeriodS;
                            stepO        <= nextStepS;
                            stepStrobeO  <= 1'b1;
                            roundStrobeO <= wrapS;
                        end else begin
                            remainR <= remainR - PERIOD_W'(1);
                        end
                        periodO    <= nextPeriodS;
                        powerO     <= nextPowerS;
                        freqPendR  <= (stateR == RUN) ? freqPendNextS : REQ_NONE;
                        powerPendR <= powerPendNextS;
                        runningO   <= 1'b1;
                        if (stateR == RUN) begin
                            stateR <= m3startI ? RUN : DECEL;
                        end else if (m3startI) begin
                            stateR <= RUN;
                        end else if (roundS && (periodO == P_MAX)) begin
                            stateR   <= IDLE;
                            powerO   <= '0;
                            runningO <= 1'b0;
                        end else begin
                            stateR <= DECEL;
                        end
                    end
                    default: begin
                        stateR <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef M3_RAMP_STATS_EN
    // Round counter and saturation indicator.
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            roundCntO <= 16'd0;
            clampO    <= 1'b0;
        end else begin
            clampO <= (freqApplyS && freqResS[PERIOD_W]) || (powerApplyS && powerResS[POWER_W]);
            if ((stateR == IDLE) && m3startI && !m3forceStopI) begin
                roundCntO <= 16'd0;
            end else if (roundS && (roundCntO != 16'hFFFF)) begin
                roundCntO <= roundCntO + 16'd1;
            end else begin
                roundCntO <= roundCntO;
            end
        end
    end
`endif

endmodule

// File: tb/tb_m3_ramp_step_sequencer.sv
// Scoreboard bench for m3_ramp_step_sequencer. Instance 0 uses the plan
// parameters (400/40/12/5); instance 1 uses a short PERIOD_MAX of 64 and
// POWER_INIT 105 so the full INC ramp, power clamps and complete deceleration
// fit in a short run. Instances are exercised one after the other.
module tb_m3_ramp_step_sequencer;

    logic clkI = 1'b0;
    always #5 clkI = ~clkI;
    logic nRstI;

    logic        startS[2], forceS[2], invS[2], fIncS[2], fDecS[2], pIncS[2], pDecS[2];
    logic [3:0]  stepS[2];
    logic        stbS[2], rndS[2], runS[2], dirS[2];
    logic [21:0] periodS[2];
    logic [9:0]  powerS[2];
`ifdef M3_RAMP_STATS_EN
    logic [15:0] rcS[2];
    logic        clampS[2];
`endif

    m3_ramp_step_sequencer #(.PERIOD_MAX(400), .PERIOD_MIN(40), .STEPS(12), .RAMP_SHIFT(5)) dutA (
        .clkI(clkI), .nRstI(nRstI), .m3startI(startS[0]), .m3forceStopI(forceS[0]),
        .m3invRotateI(invS[0]), .m3freqINCi(fIncS[0]), .m3freqDECi(fDecS[0]),
        .m3powerINCi(pIncS[0]), .m3powerDECi(pDecS[0]), .stepO(stepS[0]),
        .stepStrobeO(stbS[0]), .roundStrobeO(rndS[0]), .periodO(periodS[0]),
        .powerO(powerS[0]), .runningO(runS[0]), .dirO(dirS[0])
`ifdef M3_RAMP_STATS_EN
        , .roundCntO(rcS[0]), .clampO(clampS[0])
`endif
    );

    m3_ramp_step_sequencer #(.PERIOD_MAX(64), .PERIOD_MIN(40), .STEPS(12), .RAMP_SHIFT(5),
                             .POWER_INIT(105)) dutB (
        .clkI(clkI), .nRstI(nRstI), .m3startI(startS[1]), .m3forceStopI(forceS[1]),
        .m3invRotateI(invS[1]), .m3freqINCi(fIncS[1]), .m3freqDECi(fDecS[1]),
        .m3powerINCi(pIncS[1]), .m3powerDECi(pDecS[1]), .stepO(stepS[1]),
        .stepStrobeO(stbS[1]), .roundStrobeO(rndS[1]), .periodO(periodS[1]),
        .powerO(powerS[1]), .runningO(runS[1]), .dirO(dirS[1])
`ifdef M3_RAMP_STATS_EN
        , .roundCntO(rcS[1]), .clampO(clampS[1])
`endif
    );

    typedef struct {
        int dut;
        int step;
        bit round;
        int gap;
        int period;
        int power;
        bit dir;
        bit idle;
    } evt_t;

    evt_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   mark[2];
    logic prevRun[2];
    int   clampCnt = 0;

    // Reference state for the expected step sequence.
    int pMax[2]  = '{400, 64};
    int pInit[2] = '{100, 105};
    int mStep[2], mPer[2], mPow[2], mFP[2], mPP[2];
    bit mDir[2], mDecel[2], mIdle[2];
    int lastGap;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int faster(input int p);
        int dl;
        dl = ((p >> 5) < 1) ? 1 : (p >> 5);
        return (p - dl < 40) ? 40 : p - dl;
    endfunction

    function automatic int slower(input int p, input int mx);
        int dl;
        dl = ((p >> 5) < 1) ? 1 : (p >> 5);
        return (p + dl > mx) ? mx : p + dl;
    endfunction

    // Monitor: pops one expected step event on every stepStrobeO.
    initial begin
        evt_t e;
        mark = '{0, 0};
        prevRun = '{1'b0, 1'b0};
        forever begin
            @(negedge clkI);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (nRstI === 1'b1 && runS[d] === 1'b1 && prevRun[d] !== 1'b1) mark[d] = cyc;
`ifdef M3_RAMP_STATS_EN
                if (d == 1 && clampS[d] === 1'b1) clampCnt++;
`endif
                if (nRstI === 1'b1 && stbS[d] === 1'b1) begin
                    if (expQ.size() == 0) begin
                        chk("unexpected strobe", d, -1);
                    end else begin
                        e = expQ.pop_front();
                        chk("dut id", d, e.dut);
                        chk("step", int'(stepS[d]), e.step);
                        chk("round strobe", int'(rndS[d]), int'(e.round));
                        chk("step gap", cyc - mark[d], e.gap);
                        chk("period", int'(periodS[d]), e.period);
                        chk("power", int'(powerS[d]), e.power);
                        chk("dir", int'(dirS[d]), int'(e.dir));
                        chk("running", int'(runS[d]), e.idle ? 0 : 1);
                    end
                    mark[d] = cyc;
                end else if (nRstI === 1'b1 && rndS[d] === 1'b1) begin
                    chk("round without step strobe", d, -1);
                end
                prevRun[d] = runS[d];
            end
        end
    end

    task automatic startRun(input int d, input bit inv);
        @(negedge clkI);
        invS[d]   = inv;
        startS[d] = 1'b1;
        mStep[d] = 0; mPer[d] = pMax[d]; mPow[d] = pInit[d]; mDir[d] = inv;
        mDecel[d] = 1'b0; mIdle[d] = 1'b0; mFP[d] = 0; mPP[d] = 0;
    endtask

    task automatic pulse(input int d, input bit fi, input bit fd, input bit pi, input bit pd);
        @(negedge clkI);
        fIncS[d] = fi; fDecS[d] = fd; pIncS[d] = pi; pDecS[d] = pd;
        @(negedge clkI);
        fIncS[d] = 1'b0; fDecS[d] = 1'b0; pIncS[d] = 1'b0; pDecS[d] = 1'b0;
        if ((fi ^ fd) && !mDecel[d]) mFP[d] = fi ? 1 : 2;
        if (pi ^ pd) mPP[d] = pi ? 1 : 2;
    endtask

    task automatic stopRun(input int d);
        @(negedge clkI);
        startS[d] = 1'b0;
        mDecel[d] = 1'b1;
        mFP[d]    = 0;
    endtask

    // Push the expected next step event, then wait (bounded) for it to be consumed.
    task automatic advance(input int d);
        evt_t e;
        bit   wrap;
        int   ns;
        wrap = mDir[d] ? (mStep[d] == 0) : (mStep[d] == 11);
        if (mDir[d]) ns = wrap ? 11 : mStep[d] - 1;
        else         ns = wrap ? 0 : mStep[d] + 1;
        e.gap  = mPer[d];
        e.idle = 1'b0;
        if (wrap) begin
            if (mDecel[d]) begin
                if (mPer[d] == pMax[d]) e.idle = 1'b1;
                else mPer[d] = slower(mPer[d], pMax[d]);
            end else begin
                if (mFP[d] == 1) mPer[d] = faster(mPer[d]);
                else if (mFP[d] == 2) mPer[d] = slower(mPer[d], pMax[d]);
                mFP[d] = 0;
            end
        end
        if (mPP[d] == 1) mPow[d] = (mPow[d] + 10 > 1000) ? 1000 : mPow[d] + 10;
        else if (mPP[d] == 2) mPow[d] = (mPow[d] < 10) ? 0 : mPow[d] - 10;
        mPP[d] = 0;
        e.dut = d; e.step = ns; e.round = wrap; e.period = mPer[d];
        e.power = e.idle ? 0 : mPow[d]; e.dir = mDir[d];
        mStep[d] = ns; mIdle[d] = e.idle;
        lastGap = e.gap;
        expQ.push_back(e);
        for (int i = 0; i < lastGap + 20 && expQ.size() != 0; i++) begin
            @(negedge clkI);
            #1;
        end
        if (expQ.size() != 0) begin
            chk("strobe timeout", expQ.size(), 0);
            expQ.delete();
        end
    endtask

    initial begin
        #1200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int at40;
        nRstI = 1'b0;
        for (int d = 0; d < 2; d++) begin
            startS[d] = 1'b0; forceS[d] = 1'b0; invS[d] = 1'b0;
            fIncS[d] = 1'b0; fDecS[d] = 1'b0; pIncS[d] = 1'b0; pDecS[d] = 1'b0;
        end
        repeat (3) @(negedge clkI);
        nRstI = 1'b1;
        @(negedge clkI);
        for (int d = 0; d < 2; d++) begin
            chk("reset step", int'(stepS[d]), 0);
            chk("reset strobe", int'(stbS[d]), 0);
            chk("reset round", int'(rndS[d]), 0);
            chk("reset period", int'(periodS[d]), pMax[d]);
            chk("reset power", int'(powerS[d]), 0);
            chk("reset running", int'(runS[d]), 0);
            chk("reset dir", int'(dirS[d]), 0);
        end

        // Instance 0: first round at 400, INC mid-round, INC+DEC ignored, DECEL to IDLE.
        startRun(0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            if (i == 6) pulse(0, 1'b1, 1'b0, 1'b0, 1'b0);
            advance(0);
        end
        chk("A period after INC round", int'(periodS[0]), 388);
        for (int i = 0; i < 12; i++) begin
            if (i == 3) pulse(0, 1'b1, 1'b1, 1'b0, 1'b0);
            advance(0);
        end
        chk("A INC+DEC ignored", int'(periodS[0]), 388);
        for (int i = 0; i < 12; i++) begin
            if (i == 2) stopRun(0);
            advance(0);
        end
        for (int i = 0; i < 12; i++) advance(0);
        repeat (5) @(negedge clkI);
        chk("A idle running", int'(runS[0]), 0);
        chk("A idle power", int'(powerS[0]), 0);
        chk("A idle period", int'(periodS[0]), 400);
`ifdef M3_RAMP_STATS_EN
        chk("A round count", int'(rcS[0]), 4);
`endif

        // Instance 0: reverse rotation, direction toggle ignored, force-stop/HALT.
        startRun(0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            advance(0);
            if (i == 0) invS[0] = 1'b0;
        end
        repeat (100) @(negedge clkI);
        forceS[0] = 1'b1;
        @(negedge clkI);
        chk("A force power", int'(powerS[0]), 0);
        chk("A force running", int'(runS[0]), 0);
        repeat (500) @(negedge clkI);
        chk("A halt step frozen", int'(stepS[0]), 9);
        chk("A halt dir", int'(dirS[0]), 1);
        forceS[0] = 1'b0;
        repeat (10) @(negedge clkI);
        chk("A halt held by start", int'(runS[0]), 0);
        startS[0] = 1'b0;
        repeat (3) @(negedge clkI);
        startRun(0, 1'b0);
        repeat (5) @(negedge clkI);
        chk("A restart running", int'(runS[0]), 1);
        chk("A restart step", int'(stepS[0]), 0);
        chk("A restart power", int'(powerS[0]), 100);
        chk("A restart dir", int'(dirS[0]), 0);
        forceS[0] = 1'b1;
        @(negedge clkI);
        startS[0] = 1'b0;
        forceS[0] = 1'b0;
        repeat (3) @(negedge clkI);
        chk("A final running", int'(runS[0]), 0);

        // Instance 1: INC ramp to the period floor with power clamps, then full DECEL.
        startRun(1, 1'b0);
        k = 0;
        at40 = 0;
        while (!mDecel[1]) begin
            if (k == 11)  chk("B power floor", int'(powerS[1]), 0);
            if (k == 113) chk("B power ceiling", int'(powerS[1]), 1000);
            pulse(1, 1'b1, 1'b0, (k >= 11) && (k < 113), k < 11);
            advance(1);
            k++;
            if (mStep[1] == 0 && mPer[1] == 40) at40++;
            if (at40 == 3) begin
                chk("B period floor", int'(periodS[1]), 40);
                stopRun(1);
            end
        end
        while (!mIdle[1]) advance(1);
        repeat (5) @(negedge clkI);
        chk("B idle running", int'(runS[1]), 0);
        chk("B idle power", int'(powerS[1]), 0);
        chk("B idle period", int'(periodS[1]), 64);
`ifdef M3_RAMP_STATS_EN
        chk("B clamp seen", int'(clampCnt > 0), 1);
`endif

        repeat (50) @(negedge clkI);
        chk("scoreboard empty", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
